// File: rtl/ring_phase_monitor_if.sv
// Bundle of the ring sample, control and status signals between the ring
// counter side (master) and ring_phase_monitor (slave).
// fsm_state is a debug view of the monitor's lock FSM.
interface ring_phase_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
);
    localparam int PHASE_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   ring_in;
    logic               clear;
    logic [PHASE_W-1:0] phase;
    logic               phase_valid;
    logic               locked;
    logic               fault;
    logic               resync_req;
    logic [CNT_W-1:0]   rot_count;
    logic [ERR_W-1:0]   err_count;
    logic [1:0]         fsm_state;

    modport master (
        output ring_in, clear,
        input  phase, phase_valid, locked, fault, resync_req,
        input  rot_count, err_count, fsm_state
    );

    modport slave (
        input  ring_in, clear,
        output phase, phase_valid, locked, fault, resync_req,
        output rot_count, err_count, fsm_state
    );
endinterface

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks a one-hot ring counter's output, reports the
// hot-bit index, locks after LOCK_CNT consecutive correct steps, counts
// rotations and step errors, and pulses resync_req after a loss of lock.
// Optional feature macro: RING_PHASE_MONITOR_ERRCNT_EN compiles in the
// saturating err_count register; without it err_count reads 0.
module ring_phase_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int CNT_W    = 8,
    parameter int ERR_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    ring_phase_monitor_if.slave bus
);
    localparam int PHASE_W = $clog2(WIDTH);
    localparam int LC_W    = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2,
        FAULT    = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [LC_W-1:0]    lock_cnt, lock_cnt_next;
    logic [WIDTH-1:0]   s1, s2;
    logic [PHASE_W-1:0] phase_q;
    logic               phase_valid_q;
    logic               fault_q;
    logic [CNT_W-1:0]   rot_q;
    logic               s1_onehot;
    logic               step_ok;
    logic               rot_inc;
    logic               err_hit;

    function automatic logic is_onehot(input logic [WIDTH-1:0] x);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) n = n + 1;
        end
        return (n == 1);
    endfunction

    function automatic logic [PHASE_W-1:0] hot_index(input logic [WIDTH-1:0] x);
        logic [PHASE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) idx = PHASE_W'(i);
        end
        return idx;
    endfunction

    // The ring shifts right: next value moves the hot bit down one place.
    assign s1_onehot = is_onehot(s1);
    assign step_ok   = s1_onehot && (s1 == {s2[0], s2[WIDTH-1:1]});

    // Two-stage sample pipeline plus registered phase report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1            <= '0;
            s2            <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
        end else begin
            s1            <= bus.ring_in;
            s2            <= s1;
            phase_q       <= s1_onehot ? hot_index(s1) : '0;
            phase_valid_q <= s1_onehot;
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            lock_cnt <= lock_cnt_next;
        end
    end

    // Lock FSM next state; clear overrides every transition and event.
    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        rot_inc       = 1'b0;
        err_hit       = 1'b0;
        if (bus.clear) begin
            state_next    = UNLOCKED;
            lock_cnt_next = '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (s1_onehot) begin
                        state_next    = LOCKING;
                        lock_cnt_next = '0;
                    end
                end
                LOCKING: begin
                    if (step_ok) begin
                        lock_cnt_next = lock_cnt + LC_W'(1);
                        if (lock_cnt_next == LC_W'(LOCK_CNT)) state_next = LOCKED;
                    end else begin
                        state_next = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (step_ok) begin
                        rot_inc = s1[0];
                    end else begin
                        state_next = FAULT;
                        err_hit    = 1'b1;
                    end
                end
                FAULT: begin
                    state_next = UNLOCKED;
                end
                default: begin
                    state_next = UNLOCKED;
                end
            endcase
        end
    end

    // Sticky fault flag and wrapping rotation counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
            rot_q   <= '0;
        end else if (bus.clear) begin
            fault_q <= 1'b0;
            rot_q   <= '0;
        end else begin
            if (err_hit) fault_q <= 1'b1;
            if (rot_inc) rot_q <= rot_q + CNT_W'(1);
        end
    end

`ifdef RING_PHASE_MONITOR_ERRCNT_EN
    logic [ERR_W-1:0] err_q;

    // Saturating step-error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (bus.clear) begin
            err_q <= '0;
        end else if (err_hit && (err_q != {ERR_W{1'b1}})) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = '0;
`endif

    assign bus.phase       = phase_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.locked      = (state == LOCKED);
    assign bus.resync_req  = (state == FAULT);
    assign bus.fault       = fault_q;
    assign bus.rot_count   = rot_q;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Testbench for ring_phase_monitor: directed scenarios followed by random
// traffic, all compared against a hot-index based reference model.
module tb_ring_phase_monitor;
    localparam int W        = 4;
    localparam int LOCK_CNT = 2;
    localparam int CNT_W    = 8;
    localparam int ERR_W    = 4;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;
    localparam int ROT_MOD  = 1 << CNT_W;
`ifdef RING_PHASE_MONITOR_ERRCNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    // clock / reset
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ring_phase_monitor_if #(.WIDTH(W), .CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

    ring_phase_monitor #(
        .WIDTH(W), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W), .ERR_W(ERR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: samples held as hot index (-1 = not one-hot)
    localparam int M_UNL = 0, M_LOCKING = 1, M_LOCKED = 2, M_FAULT = 3;
    int m_h1, m_h2, m_mode, m_run, m_fault, m_rot, m_err, m_phase, m_pv;
    int cur;

    function automatic int hot_idx(input logic [3:0] v);
        int n   = 0;
        int idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                n++;
                idx = i;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic logic [3:0] onehot_of(input int i);
        logic [3:0] t;
        t = 4'b0001;
        return t << i;
    endfunction

    task automatic model_reset();
        m_h1 = -1; m_h2 = -1; m_mode = M_UNL; m_run = 0;
        m_fault = 0; m_rot = 0; m_err = 0; m_phase = 0; m_pv = 0;
    endtask

    task automatic model_edge(input logic [3:0] v, input logic c);
        int good;
        good = (m_h1 >= 0) && (m_h2 >= 0) && (m_h1 == (m_h2 + W - 1) % W);
        if (c) begin
            m_mode = M_UNL; m_run = 0; m_fault = 0; m_rot = 0; m_err = 0;
        end else if (m_mode == M_UNL) begin
            if (m_h1 >= 0) begin
                m_mode = M_LOCKING;
                m_run  = 0;
            end
        end else if (m_mode == M_LOCKING) begin
            if (good) begin
                m_run++;
                if (m_run == LOCK_CNT) m_mode = M_LOCKED;
            end else begin
                m_mode = M_UNL;
            end
        end else if (m_mode == M_LOCKED) begin
            if (good) begin
                if (m_h1 == 0) m_rot = (m_rot + 1) % ROT_MOD;
            end else begin
                m_mode  = M_FAULT;
                m_fault = 1;
                if (m_err < ERR_MAX) m_err++;
            end
        end else begin
            m_mode = M_UNL;
        end
        m_phase = (m_h1 >= 0) ? m_h1 : 0;
        m_pv    = (m_h1 >= 0);
        m_h2    = m_h1;
        m_h1    = hot_idx(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: compare every output against the model
    task automatic check_all();
        chk("phase",       32'(bus.phase),       m_phase);
        chk("phase_valid", 32'(bus.phase_valid), m_pv);
        chk("locked",      32'(bus.locked),      (m_mode == M_LOCKED));
        chk("fault",       32'(bus.fault),       m_fault);
        chk("resync_req",  32'(bus.resync_req),  (m_mode == M_FAULT));
        chk("rot_count",   32'(bus.rot_count),   m_rot);
        chk("err_count",   32'(bus.err_count),   ERR_EN ? m_err : 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_phase"},  32'(bus.phase),       0);
        chk({tag, "_pv"},     32'(bus.phase_valid), 0);
        chk({tag, "_locked"}, 32'(bus.locked),      0);
        chk({tag, "_fault"},  32'(bus.fault),       0);
        chk({tag, "_resync"}, 32'(bus.resync_req),  0);
        chk({tag, "_rot"},    32'(bus.rot_count),   0);
        chk({tag, "_err"},    32'(bus.err_count),   0);
    endtask

    // driver: apply one sample, clock it, update model, check
    task automatic cycle(input logic [3:0] v, input logic c);
        bus.ring_in = v;
        bus.clear   = c;
        @(posedge clk);
        model_edge(v, c);
        #1;
        check_all();
    endtask

    task automatic rotate(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(onehot_of(cur), 1'b0);
            cur = (cur + W - 1) % W;
        end
    endtask

    initial begin
        int r;
        int prev_rot;
        int wrap_seen;
        logic [3:0] held;

        bus.ring_in = '0;
        bus.clear   = 1'b0;
        reset       = 1'b1;
        model_reset();
        #8;
        check_zero("reset");
        #4;
        reset = 1'b0;

        // lock timing from edge 0
        cycle(4'b1000, 1'b0);
        cycle(4'b0100, 1'b0);
        chk("phase_e1", 32'(bus.phase), 3);
        cycle(4'b0010, 1'b0);
        chk("phase_e2", 32'(bus.phase), 2);
        chk("locked_e2", 32'(bus.locked), 0);
        cycle(4'b0001, 1'b0);
        chk("phase_e3", 32'(bus.phase), 1);
        chk("locked_e3", 32'(bus.locked), 1);
        cur = 3;
        rotate(9);

        // single bad sample while locked
        cycle(4'b0110, 1'b0);
        rotate(1);
        chk("fault_set", 32'(bus.fault), 1);
        chk("resync_pulse", 32'(bus.resync_req), 1);
        rotate(1);
        chk("resync_drop", 32'(bus.resync_req), 0);
        chk("unlocked_after_fault", 32'(bus.locked), 0);
        chk("err_one", 32'(bus.err_count), ERR_EN ? 1 : 0);
        rotate(3);
        chk("relocked", 32'(bus.locked), 1);
        rotate(4);

        // all-zero and stuck inputs never lock
        for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0);
        chk("zero_pv", 32'(bus.phase_valid), 0);
        chk("zero_unlocked", 32'(bus.locked), 0);
        for (int i = 0; i < 10; i++) cycle(4'b0100, 1'b0);
        chk("stuck_unlocked", 32'(bus.locked), 0);

        // error saturation
        cycle(onehot_of(cur), 1'b1);
        cur = (cur + W - 1) % W;
        chk("clear_fault", 32'(bus.fault), 0);
        for (int i = 0; i < 20; i++) begin
            rotate(5);
            cycle(4'b0110, 1'b0);
        end
        rotate(3);
        chk("err_sat", 32'(bus.err_count), ERR_EN ? ERR_MAX : 0);

        // rotation counter wrap
        cycle(onehot_of(cur), 1'b1);
        cur = (cur + W - 1) % W;
        wrap_seen = 0;
        for (int i = 0; i < 1040; i++) begin
            prev_rot = int'(bus.rot_count);
            rotate(1);
            if (prev_rot == ROT_MOD - 1 && int'(bus.rot_count) == 0) wrap_seen = 1;
        end
        chk("rot_wrap_seen", wrap_seen, 1);

        // clear on the same edge as an error in LOCKED
        rotate(6);
        chk("locked_before_clear", 32'(bus.locked), 1);
        cycle(4'b0110, 1'b0);
        cycle(onehot_of(cur), 1'b1);
        cur = (cur + W - 1) % W;
        chk("clr_err_fault", 32'(bus.fault), 0);
        chk("clr_err_count", 32'(bus.err_count), 0);
        chk("clr_err_resync", 32'(bus.resync_req), 0);
        chk("clr_err_locked", 32'(bus.locked), 0);
        rotate(1);
        chk("clr_err_resync_next", 32'(bus.resync_req), 0);

        // asynchronous reset mid-rotation
        rotate(10);
        chk("locked_before_reset", 32'(bus.locked), 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_zero("async_reset");
        #1;
        reset = 1'b0;

        // random traffic
        held = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 80) begin
                held = onehot_of(cur);
                cycle(held, 1'b0);
                cur = (cur + W - 1) % W;
            end else if (r < 92) begin
                held = 4'($urandom_range(0, 15));
                cycle(held, 1'b0);
            end else if (r < 96) begin
                cycle(held, 1'b0);
            end else begin
                held = onehot_of(cur);
                cycle(held, 1'b1);
                cur = (cur + W - 1) % W;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ring_phase_monitor.md
# ring_phase_monitor

Downstream companion to the team's one-hot ring counter: samples the ring's parallel output every clock, checks that it holds exactly one hot bit and that the bit moves one position per clock in the ring's shift direction, and reports the binary phase index. Gates a `locked` indication after a run of consecutive correct steps. Counts full rotations and step errors, and issues a one-cycle resync request so upstream control can reload the ring's seed.

## Interface
- `WIDTH`, 4: ring width in bits; must be ≥ 2. `PHASE_W = $clog2(WIDTH)` is derived locally.
- `LOCK_CNT`, 2: consecutive correct steps required to lock; must be ≥ 1.
- `CNT_W`, 8: rotation counter width.
- `ERR_W`, 4: error counter width.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high; clears every register.
- `ring_in` in WIDTH: parallel output of the ring counter.
- `clear` in 1: synchronous clear of counters and sticky fault; also forces the FSM to UNLOCKED.
- `phase` out PHASE_W: binary index of the hot bit in the sample.
- `phase_valid` out 1: the sample was exactly one-hot.
- `locked` out 1: high while the FSM is in LOCKED.
- `fault` out 1: sticky; set on any error seen while LOCKED.
- `resync_req` out 1: one-cycle pulse while the FSM is in FAULT.
- `rot_count` out CNT_W: number of completed rotations; wraps modulo 2^CNT_W.
- `err_count` out ERR_W: number of step errors; saturates at all-ones.

## Operation
Sampling:
- `s1 <= ring_in` every edge; `s2 <= s1`.
- `onehot(x)`: exactly one bit of x is set. All-zero and multi-hot values are invalid.
- Expected next value: `rot(x) = {x[0], x[WIDTH-1:1]}`. The hot index decreases by 1 per clock and wraps from 0 to WIDTH-1.
- `step_ok = onehot(s1) && (s1 == rot(s2))`.
- Each edge: `phase <= index(s1)` and `phase_valid <= onehot(s1)`. When `s1` is not one-hot, `phase` is 0.

FSM (state register, evaluated every edge on the old `s1`/`s2`):
- UNLOCKED: if `onehot(s1)`, go to LOCKING with `lock_cnt = 0`.
- LOCKING:
  - `step_ok`: increment `lock_cnt`; when it reaches LOCK_CNT, go to LOCKED.
  - otherwise: go to UNLOCKED.
- LOCKED:
  - `step_ok`: stay in LOCKED; if `s1[0]` is set, increment `rot_count`.
  - otherwise: go to FAULT, set `fault`, increment `err_count` (saturating).
- FAULT: `resync_req` = 1 for exactly this cycle; unconditionally go to UNLOCKED.

`clear` (synchronous, highest priority after reset):
- `rot_count`, `err_count` and `fault` go to 0; FSM goes to UNLOCKED.
- If `clear` coincides with an error in LOCKED, `clear` wins: no fault, no count, no FAULT state.

## Timing
- Reset values: `phase` 0, `phase_valid` 0, `locked` 0, `fault` 0, `resync_req` 0, `rot_count` 0, `err_count` 0, FSM UNLOCKED, `s1` = `s2` = 0, `lock_cnt` 0.
- Latency:
  - `ring_in` sampled at edge k appears on `phase`/`phase_valid` after edge k+1.
  - Its step check affects FSM outputs after edge k+1.
- Lock timing: with a correctly rotating one-hot input from edge 0 and LOCK_CNT=2:
  - edge 1: UNLOCKED → LOCKING.
  - edge 2: first good step.
  - edge 3: LOCKED; `locked` is high from edge 3.
- Fault timing: a bad sample at edge k while LOCKED causes:
  - `fault` high and `resync_req` high after edge k+1;
  - `resync_req` low and UNLOCKED after edge k+2.
- Rotation count: `rot_count` increments only in LOCKED, on the edge whose `s1` has bit 0 hot. Wrap from all-ones to 0 is silent.
- Asserting `reset` mid-operation clears everything immediately, without waiting for a clock edge.

## Configuration
- `RING_PHASE_MONITOR_ERRCNT_EN`:
  - Defined: the `err_count` register and its saturating increment are compiled in.
  - Undefined: no error counter register exists and `err_count` is tied to 0. The `fault` and `resync_req` behaviour is unchanged.

## Test plan
- Reset, then drive `ring_in` = 1000, 0100, 0010, 0001, … from edge 0 → `locked` high after edge 3; `phase` follows 3, 2, 1, 0; `rot_count` increments by 1 per 4 clocks.
- While locked, inject 0110 for one cycle → `fault` = 1, one-cycle `resync_req`, `err_count` = 1 (0 with the macro undefined), FSM back to UNLOCKED, then relock 3 cycles after valid rotation resumes.
- Hold `ring_in` = 0000 → `phase_valid` = 0 and the FSM stays UNLOCKED; hold `ring_in` = 0100 (stuck) → never reaches LOCKED.
- Inject 20 errors → `err_count` saturates at 15; rotate 256 rotations → `rot_count` wraps to 0.
- Assert `clear` on the same edge as an error in LOCKED → `fault` = 0, `err_count` = 0, no `resync_req`, FSM UNLOCKED.
- Assert `reset` mid-rotation while locked → all outputs 0 immediately, before the next edge.
